// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO controller: op encoding, FSM states and the
// divide-by-zero LO constant.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_START = 2'd1,
    DIV_WAIT  = 2'd2,
    DIV_FIX   = 2'd3
  } hilo_state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// Architectural HI/LO registers plus the sequencer that drives an external
// unsigned multi-cycle divider and applies the signed-result fixup.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | accepting ops; MULT/MTxx/div-by-0 complete in one edge
//   DIV_START | one-cycle start pulse to Div, wait timer loaded
//   DIV_WAIT  | waiting for Div done pulse or timer expiry
//   DIV_FIX   | apply quotient/remainder signs and write HI/LO
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  hilo_op_t    op,
  output logic        op_ready,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        rd_hilo,
  output logic        stall,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        div_validIn,
  output logic [31:0] div_SrcA,
  output logic [31:0] div_SrcB,
  input  logic        div_validOut,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        div_timeout
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_TIMEOUT - 1);

  hilo_state_t      state_q, state_d;
  logic [31:0]      hi_d, lo_d;
  logic [31:0]      opa_q, opa_d, opb_q, opb_d;
  logic [31:0]      quot_q, quot_d, rem_q, rem_d;
  logic             sign_q, sign_d, remsign_q, remsign_d;
  logic             timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      prod_s, prod_u;
  logic             busy, accept;

  assign prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
  assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  assign busy        = (state_q != IDLE);
  assign op_ready    = (state_q == IDLE);
  assign accept      = op_valid & op_ready;
  assign stall       = busy & (op_valid | rd_hilo);
  assign div_validIn = (state_q == DIV_START);
  assign div_SrcA    = opa_q;
  assign div_SrcB    = opb_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    sign_d    = sign_q;
    remsign_d = remsign_q;
    timeout_d = div_timeout;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT: {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MTHI: hi_d = SrcA;
            OP_MTLO: lo_d = SrcA;
            OP_DIV, OP_DIVU: begin
              if (SrcB == 32'd0) begin
                hi_d = SrcA;
                lo_d = DIV0_LO;
              end else if (op == OP_DIV) begin
                opa_d     = abs32(SrcA);
                opb_d     = abs32(SrcB);
                sign_d    = SrcA[31] ^ SrcB[31];
                remsign_d = SrcA[31];
                state_d   = DIV_START;
              end else begin
                opa_d     = SrcA;
                opb_d     = SrcB;
                sign_d    = 1'b0;
                remsign_d = 1'b0;
                state_d   = DIV_START;
              end
            end
            default: ;
          endcase
        end
      end

      DIV_START: begin
        cnt_d   = CNT_LOAD;
        state_d = DIV_WAIT;
      end

      // Done pulse wins over timer expiry on the last allowed cycle.
      DIV_WAIT: begin
        if (div_validOut) begin
          quot_d  = div_quot;
          rem_d   = div_rem;
          state_d = DIV_FIX;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DIV_FIX: begin
        lo_d    = sign_q ? (32'd0 - quot_q) : quot_q;
        hi_d    = remsign_q ? (32'd0 - rem_q) : rem_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      sign_q      <= 1'b0;
      remsign_q   <= 1'b0;
      div_timeout <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      sign_q      <= sign_d;
      remsign_q   <= remsign_d;
      div_timeout <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
